// File: rtl/multdiv_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_pkg
//   Shared definitions for the multiply/divide sequencer:
//     - request opcodes presented by the control unit (OP_*)
//     - engine control codes carried on eng_ctrl (ENG_*)
//     - sequencer state encoding (state_t)
// -----------------------------------------------------------------------------
package multdiv_pkg;

  // Control-unit opcodes; code 7 is reserved and behaves like OP_NOP.
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MFHI = 3'd3;
  localparam logic [2:0] OP_MFLO = 3'd4;
  localparam logic [2:0] OP_MTHI = 3'd5;
  localparam logic [2:0] OP_MTLO = 3'd6;

  // Engine control codes. ENG_IDLE also tells the engine to drop any
  // result it might still deliver for an abandoned operation.
  localparam logic [1:0] ENG_IDLE = 2'b00;
  localparam logic [1:0] ENG_MULT = 2'b01;
  localparam logic [1:0] ENG_DIV  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/multdiv_watchdog.sv
// -----------------------------------------------------------------------------
// multdiv_watchdog
//   Cycle counter that guards the engine handshake.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     clear      : force the count to zero (operation being launched)
//     enable     : count this cycle (waiting, no engine result yet)
//     expired    : high in the cycle the count sits at TIMEOUT-1 while enabled;
//                  the sequencer registers it into its timeout pulse
//   The count saturates at TIMEOUT-1 instead of wrapping.
// -----------------------------------------------------------------------------
module multdiv_watchdog #(
  parameter int TIMEOUT = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/multdiv_sequencer.sv
// -----------------------------------------------------------------------------
// multdiv_sequencer
//   Initiator side of the iterative multiply/divide engine. Accepts HI/LO-class
//   requests, launches the engine with a start/done handshake, owns the
//   architectural Hi/Lo registers and serves MFHI/MFLO/MTHI/MTLO locally.
//   Ports:
//     clk, reset              : clock, synchronous active-high reset
//     req_valid/op/a/b        : request from the control unit
//     req_ready               : request can be accepted this cycle
//     busy                    : MULT/DIV in flight, stalls the control unit
//     rd_valid, rd_data       : one-cycle MFHI/MFLO result
//     hi, lo                  : architectural Hi/Lo registers
//     op_done                 : one-cycle pulse when MULT/DIV commits
//     div_zero, timeout       : one-cycle exception pulses
//     eng_start/ctrl/a/b      : launch pulse, op code and operands to engine
//     eng_done/hi/lo/divzero  : engine result handshake
// -----------------------------------------------------------------------------
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             req_ready,
  output logic             busy,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             op_done,
  output logic             div_zero,
  output logic             timeout,
  output logic             eng_start,
  output logic [1:0]       eng_ctrl,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_hi,
  input  logic [WIDTH-1:0] eng_lo,
  input  logic             eng_divzero
);

  state_t state;
  logic   wd_expired;

  assign req_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);

  // The watchdog restarts while the launch pulse is out and counts only WAIT
  // cycles without a result, so a done on the final cycle still wins.
  multdiv_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == ISSUE),
    .enable  ((state == WAIT) && !eng_done),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: hi/lo are architectural state and are cleared on reset, as are
      // the engine-facing registers so an aborted operation cannot linger.
      state     <= IDLE;
      hi        <= '0;
      lo        <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      op_done   <= 1'b0;
      div_zero  <= 1'b0;
      timeout   <= 1'b0;
      eng_start <= 1'b0;
      eng_ctrl  <= ENG_IDLE;
      eng_a     <= '0;
      eng_b     <= '0;
    end else begin
      // Pulse outputs default low; each branch raises the one it owns.
      rd_valid  <= 1'b0;
      op_done   <= 1'b0;
      div_zero  <= 1'b0;
      timeout   <= 1'b0;
      eng_start <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid) begin
            case (req_op)
              OP_MFHI: begin
                rd_data  <= hi;
                rd_valid <= 1'b1;
              end
              OP_MFLO: begin
                rd_data  <= lo;
                rd_valid <= 1'b1;
              end
              OP_MTHI: hi <= req_a;
              OP_MTLO: lo <= req_a;
              OP_MULT: begin
                eng_a     <= req_a;
                eng_b     <= req_b;
                eng_ctrl  <= ENG_MULT;
                eng_start <= 1'b1;
                state     <= ISSUE;
              end
              OP_DIV: begin
                // A zero divisor is trapped here; the engine never sees it.
                if (req_b == '0) begin
                  div_zero <= 1'b1;
                end else begin
                  eng_a     <= req_a;
                  eng_b     <= req_b;
                  eng_ctrl  <= ENG_DIV;
                  eng_start <= 1'b1;
                  state     <= ISSUE;
                end
              end
              default: ; // NOP and reserved code
            endcase
          end
        end

        // eng_start is high for this cycle only; eng_done is ignored here.
        ISSUE: state <= WAIT;

        WAIT: begin
          if (eng_done) begin
            if (eng_divzero) begin
              div_zero <= 1'b1;
            end else begin
              hi      <= eng_hi;
              lo      <= eng_lo;
              op_done <= 1'b1;
            end
            eng_ctrl <= ENG_IDLE;
            state    <= IDLE;
          end else if (wd_expired) begin
            timeout  <= 1'b1;
            eng_ctrl <= ENG_IDLE;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multdiv_sequencer
//   Self-checking bench for multdiv_sequencer. A behavioural engine model
//   answers launches after a programmable latency with a signed product or
//   signed quotient/remainder; a reference Hi/Lo pair tracks the expected
//   architectural state. Inputs change and outputs are sampled 1 time unit
//   after each rising edge.
// -----------------------------------------------------------------------------
module tb_multdiv_sequencer;
  import multdiv_pkg::*;

  localparam int W  = 32;
  localparam int TO = 40;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic [2:0]   req_op;
  logic [W-1:0] req_a, req_b;
  logic         req_ready, busy, rd_valid, op_done, div_zero, timeout, eng_start;
  logic [W-1:0] rd_data, hi, lo, eng_a, eng_b;
  logic [1:0]   eng_ctrl;
  logic         eng_done, eng_divzero;
  logic [W-1:0] eng_hi, eng_lo;

  multdiv_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .busy(busy),
    .rd_valid(rd_valid), .rd_data(rd_data), .hi(hi), .lo(lo),
    .op_done(op_done), .div_zero(div_zero), .timeout(timeout),
    .eng_start(eng_start), .eng_ctrl(eng_ctrl), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_hi(eng_hi), .eng_lo(eng_lo), .eng_divzero(eng_divzero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference architectural state.
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  // Engine model configuration and state.
  int          eng_lat      = 5;
  bit          eng_hang     = 1'b0;
  bit          eng_force_dz = 1'b0;
  bit          eng_armed    = 1'b0;
  int          eng_remain   = 0;
  logic [63:0] eng_pending  = '0;

  // Signed multiply gives {hi,lo}; signed divide gives {remainder,quotient}.
  function automatic logic [63:0] ref_result(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      p = sa * sb;
      return p;
    end
    if (sb == 0) return '0;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Advance one clock and let the engine model react to what it sees.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    eng_done    = 1'b0;
    eng_divzero = 1'b0;
    if (eng_armed) begin
      eng_remain--;
      if (eng_remain == 0) begin
        eng_armed   = 1'b0;
        eng_done    = 1'b1;
        eng_divzero = eng_force_dz;
        {eng_hi, eng_lo} = eng_pending;
      end
    end
    if (eng_start && !eng_hang) begin
      eng_armed   = 1'b1;
      eng_remain  = eng_lat;
      eng_pending = ref_result(eng_ctrl == ENG_DIV, eng_a, eng_b);
    end
  endtask

  // Present one request for a single cycle; returns in the cycle after acceptance.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready op=%0d: req_ready=%b expected 1", op, req_ready);
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    step();
    req_valid = 1'b0; req_op = OP_NOP;
  endtask

  // Step until a completion pulse, bounded; n = steps taken.
  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!(op_done || div_zero || timeout) && n < bound) begin
      step();
      n++;
    end
    checks++;
    if (!(op_done || div_zero || timeout)) begin
      errors++;
      $display("FAIL wait_bound: no completion pulse within %0d cycles", bound);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = OP_NOP; req_a = '0; req_b = '0;
    eng_done = 1'b0; eng_divzero = 1'b0; eng_hi = '0; eng_lo = '0;
    step(); step();
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_low: req_ready=%b expected 0", req_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({req_ready, busy} !== 2'b10) begin
      errors++; $display("FAIL reset_ready_busy: got %b expected 10", {req_ready, busy});
    end
    checks++;
    if ({hi, lo, rd_data, eng_a, eng_b} !== '0 || eng_ctrl !== ENG_IDLE) begin
      errors++; $display("FAIL reset_regs: hi=%h lo=%h rd=%h a=%h b=%h ctrl=%b expected all 0",
                         hi, lo, rd_data, eng_a, eng_b, eng_ctrl);
    end
    checks++;
    if ({rd_valid, op_done, div_zero, timeout, eng_start} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses: got %b expected 00000",
                         {rd_valid, op_done, div_zero, timeout, eng_start});
    end
  endtask

  task automatic test_move_read();
    issue(OP_MTHI, 32'h0000_1234, $urandom);
    model_hi = 32'h0000_1234;
    checks++;
    if (hi !== model_hi || rd_valid !== 1'b0) begin
      errors++; $display("FAIL mthi: hi=%h rd_valid=%b expected %h 0", hi, rd_valid, model_hi);
    end
    issue(OP_MFHI, '0, '0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h0000_1234) begin
      errors++; $display("FAIL mfhi: rd_valid=%b rd_data=%h expected 1 00001234", rd_valid, rd_data);
    end
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL rd_valid_pulse: rd_valid=%b expected 0", rd_valid);
    end
    model_lo = $urandom;
    issue(OP_MTLO, model_lo, '0);
    issue(OP_MFLO, '0, '0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== model_lo || lo !== model_lo) begin
      errors++; $display("FAIL mflo: rd_valid=%b rd_data=%h lo=%h expected 1 %h", rd_valid, rd_data, lo, model_lo);
    end
    issue(OP_NOP, $urandom, $urandom);
    issue(3'd7, $urandom, $urandom);
    checks++;
    if ({hi, lo} !== {model_hi, model_lo} || {busy, rd_valid, op_done, div_zero, eng_start} !== 5'b0) begin
      errors++; $display("FAIL nop_reserved: hi=%h lo=%h flags=%b expected %h %h 00000",
                         hi, lo, {busy, rd_valid, op_done, div_zero, eng_start}, model_hi, model_lo);
    end
  endtask

  task automatic test_mult_latency();
    eng_lat = 33;
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    checks++;
    if ({eng_ctrl, eng_a, eng_b} !== {ENG_MULT, 32'hFFFF_FFFE, 32'd3}) begin
      errors++; $display("FAIL mult_launch: ctrl=%b a=%h b=%h expected 01 fffffffe 00000003", eng_ctrl, eng_a, eng_b);
    end
    for (int k = 1; k <= 34; k++) begin
      checks++;
      if ({busy, req_ready, eng_start, op_done} !== {1'b1, 1'b0, (k == 1), 1'b0}) begin
        errors++; $display("FAIL mult_inflight cycle %0d: busy/ready/start/done=%b expected %b",
                           k, {busy, req_ready, eng_start, op_done}, {1'b1, 1'b0, (k == 1), 1'b0});
      end
      if (k == 34) begin
        checks++;
        if ({hi, lo} !== {model_hi, model_lo}) begin
          errors++; $display("FAIL mult_early_commit: hi=%h lo=%h expected %h %h", hi, lo, model_hi, model_lo);
        end
      end
      step();
    end
    model_hi = 32'hFFFF_FFFF;
    model_lo = 32'hFFFF_FFFA;
    checks++;
    if ({op_done, req_ready, busy} !== 3'b110 || {hi, lo} !== {model_hi, model_lo} || eng_ctrl !== ENG_IDLE) begin
      errors++; $display("FAIL mult_commit: done/ready/busy=%b hi=%h lo=%h ctrl=%b expected 110 ffffffff fffffffa 00",
                         {op_done, req_ready, busy}, hi, lo, eng_ctrl);
    end
    step();
    checks++;
    if (op_done !== 1'b0) begin
      errors++; $display("FAIL op_done_pulse: op_done=%b expected 0", op_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [63:0] res;
    int n;
    bit early;
    // MFLO held while a MULT is in flight.
    a = $urandom; b = $urandom;
    eng_lat = 8;
    issue(OP_MULT, a, b);
    res = ref_result(1'b0, a, b);
    req_valid = 1'b1; req_op = OP_MFLO; req_a = '0; req_b = '0;
    n = 0; early = 1'b0;
    while (!op_done && n < 50) begin
      if (rd_valid || req_ready) early = 1'b1;
      step();
      n++;
    end
    checks++;
    if (early) begin
      errors++; $display("FAIL mflo_stall: request served or ready during WAIT (got 1, expected 0)");
    end
    checks++;
    if ({op_done, req_ready} !== 2'b11 || n != eng_lat + 1 || lo !== res[31:0]) begin
      errors++; $display("FAIL held_commit: done/ready=%b steps=%0d lo=%h expected 11 %0d %h",
                         {op_done, req_ready}, n, lo, eng_lat + 1, res[31:0]);
    end
    {model_hi, model_lo} = res;
    step();
    req_valid = 1'b0; req_op = OP_NOP;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== model_lo) begin
      errors++; $display("FAIL held_mflo: rd_valid=%b rd_data=%h expected 1 %h", rd_valid, rd_data, model_lo);
    end
    // DIV accepted in the op_done cycle of the previous MULT.
    step();
    a = $urandom; b = $urandom | 32'h1;
    eng_lat = 4;
    issue(OP_MULT, a, b);
    wait_done(50, n);
    {model_hi, model_lo} = ref_result(1'b0, a, b);
    a = $urandom; b = $urandom_range(1, 1000);
    issue(OP_DIV, a, b);
    checks++;
    if (eng_start !== 1'b1 || eng_ctrl !== ENG_DIV || {hi, lo} !== {model_hi, model_lo}) begin
      errors++; $display("FAIL b2b_launch: start=%b ctrl=%b hi=%h lo=%h expected 1 10 %h %h",
                         eng_start, eng_ctrl, hi, lo, model_hi, model_lo);
    end
    wait_done(50, n);
    {model_hi, model_lo} = ref_result(1'b1, a, b);
    checks++;
    if (op_done !== 1'b1 || {hi, lo} !== {model_hi, model_lo}) begin
      errors++; $display("FAIL b2b_div: op_done=%b hi=%h lo=%h expected 1 %h %h", op_done, hi, lo, model_hi, model_lo);
    end
  endtask

  task automatic test_div_zero();
    int n;
    issue(OP_DIV, 32'd7, 32'd0);
    checks++;
    if ({div_zero, eng_start, busy, op_done} !== 4'b1000 || {hi, lo} !== {model_hi, model_lo} || eng_ctrl !== ENG_IDLE) begin
      errors++; $display("FAIL div_zero_trap: dz/start/busy/done=%b hi=%h lo=%h ctrl=%b expected 1000 %h %h 00",
                         {div_zero, eng_start, busy, op_done}, hi, lo, eng_ctrl, model_hi, model_lo);
    end
    step();
    checks++;
    if ({div_zero, eng_start} !== 2'b00) begin
      errors++; $display("FAIL div_zero_pulse: dz/start=%b expected 00", {div_zero, eng_start});
    end
    eng_force_dz = 1'b1;
    eng_lat = 5;
    issue(OP_DIV, 32'd100, 32'd7);
    wait_done(50, n);
    checks++;
    if ({div_zero, op_done} !== 2'b10 || {hi, lo} !== {model_hi, model_lo} || eng_ctrl !== ENG_IDLE) begin
      errors++; $display("FAIL engine_divzero: dz/done=%b hi=%h lo=%h ctrl=%b expected 10 %h %h 00",
                         {div_zero, op_done}, hi, lo, eng_ctrl, model_hi, model_lo);
    end
    eng_force_dz = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    eng_hang = 1'b1;
    issue(OP_MULT, $urandom, $urandom);
    checks++;
    if (eng_start !== 1'b1) begin
      errors++; $display("FAIL timeout_launch: eng_start=%b expected 1", eng_start);
    end
    n = 0;
    while (!timeout && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (timeout !== 1'b1 || n != TO + 1) begin
      errors++; $display("FAIL timeout_latency: timeout=%b cycles after start=%0d expected 1 %0d", timeout, n, TO + 1);
    end
    checks++;
    if ({busy, req_ready, op_done} !== 3'b010 || {hi, lo} !== {model_hi, model_lo} || eng_ctrl !== ENG_IDLE) begin
      errors++; $display("FAIL timeout_state: busy/ready/done=%b hi=%h lo=%h ctrl=%b expected 010 %h %h 00",
                         {busy, req_ready, op_done}, hi, lo, eng_ctrl, model_hi, model_lo);
    end
    step();
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: timeout=%b expected 0", timeout);
    end
    eng_hang = 1'b0;
  endtask

  task automatic test_spurious_done();
    logic [31:0] a, b;
    int n;
    // Done while IDLE.
    eng_done = 1'b1; eng_hi = $urandom; eng_lo = $urandom;
    step();
    checks++;
    if ({hi, lo} !== {model_hi, model_lo} || {op_done, busy} !== 2'b00) begin
      errors++; $display("FAIL idle_done: hi=%h lo=%h done/busy=%b expected %h %h 00",
                         hi, lo, {op_done, busy}, model_hi, model_lo);
    end
    // Done during ISSUE.
    a = $urandom; b = $urandom;
    eng_lat = 6;
    issue(OP_MULT, a, b);
    eng_done = 1'b1; eng_hi = ~model_hi; eng_lo = ~model_lo;
    step();
    checks++;
    if ({op_done, busy} !== 2'b01 || {hi, lo} !== {model_hi, model_lo}) begin
      errors++; $display("FAIL issue_done: done/busy=%b hi=%h lo=%h expected 01 %h %h",
                         {op_done, busy}, hi, lo, model_hi, model_lo);
    end
    wait_done(50, n);
    {model_hi, model_lo} = ref_result(1'b0, a, b);
    checks++;
    if (op_done !== 1'b1 || n != eng_lat || {hi, lo} !== {model_hi, model_lo}) begin
      errors++; $display("FAIL issue_done_commit: done=%b steps=%0d hi=%h lo=%h expected 1 %0d %h %h",
                         op_done, n, hi, lo, eng_lat, model_hi, model_lo);
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    issue(OP_MTHI, 32'hA5A5_0001, '0);
    issue(OP_MTLO, 32'h5A5A_0002, '0);
    model_hi = 32'hA5A5_0001; model_lo = 32'h5A5A_0002;
    eng_lat = 30;
    issue(OP_DIV, 32'd1000, 32'd7);
    for (int k = 0; k < 9; k++) step();
    reset = 1'b1;
    step();
    model_hi = '0; model_lo = '0;
    checks++;
    if ({busy, req_ready} !== 2'b00 || {hi, lo} !== '0 || eng_ctrl !== ENG_IDLE) begin
      errors++; $display("FAIL reset_abort: busy/ready=%b hi=%h lo=%h ctrl=%b expected 00 0 0 00",
                         {busy, req_ready}, hi, lo, eng_ctrl);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: req_ready=%b expected 1", req_ready);
    end
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (op_done || div_zero || busy) seen = 1'b1;
    end
    checks++;
    if (seen || {hi, lo} !== '0) begin
      errors++; $display("FAIL late_done: reacted=%b hi=%h lo=%h expected 0 0 0", seen, hi, lo);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] res;
    int n;
    for (int it = 0; it < 60; it++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      eng_lat = $urandom_range(1, 12);
      eng_force_dz = (op == OP_DIV) && ($urandom_range(0, 7) == 0);
      issue(op, a, b);
      case (op)
        OP_MFHI, OP_MFLO: begin
          checks++;
          if (rd_valid !== 1'b1 || rd_data !== ((op == OP_MFHI) ? model_hi : model_lo)) begin
            errors++; $display("FAIL rand_read it=%0d: rd_valid=%b rd_data=%h expected 1 %h",
                               it, rd_valid, rd_data, (op == OP_MFHI) ? model_hi : model_lo);
          end
        end
        OP_MTHI, OP_MTLO: begin
          if (op == OP_MTHI) model_hi = a; else model_lo = a;
          checks++;
          if ({hi, lo} !== {model_hi, model_lo}) begin
            errors++; $display("FAIL rand_move it=%0d: hi=%h lo=%h expected %h %h", it, hi, lo, model_hi, model_lo);
          end
        end
        OP_MULT, OP_DIV: begin
          if (op == OP_DIV && b == 32'd0) begin
            checks++;
            if ({div_zero, eng_start, busy} !== 3'b100 || {hi, lo} !== {model_hi, model_lo}) begin
              errors++; $display("FAIL rand_div0 it=%0d: dz/start/busy=%b hi=%h lo=%h expected 100 %h %h",
                                 it, {div_zero, eng_start, busy}, hi, lo, model_hi, model_lo);
            end
          end else begin
            checks++;
            if ({eng_start, eng_ctrl, eng_a, eng_b} !== {1'b1, (op == OP_MULT) ? ENG_MULT : ENG_DIV, a, b}) begin
              errors++; $display("FAIL rand_launch it=%0d: start=%b ctrl=%b a=%h b=%h expected 1 %b %h %h",
                                 it, eng_start, eng_ctrl, eng_a, eng_b, (op == OP_MULT) ? ENG_MULT : ENG_DIV, a, b);
            end
            wait_done(50, n);
            if (!eng_force_dz) begin
              res = ref_result(op == OP_DIV, a, b);
              {model_hi, model_lo} = res;
            end
            checks++;
            if ({op_done, div_zero} !== (eng_force_dz ? 2'b01 : 2'b10) || n != eng_lat + 1 ||
                {hi, lo} !== {model_hi, model_lo}) begin
              errors++; $display("FAIL rand_op it=%0d op=%0d: done/dz=%b steps=%0d hi=%h lo=%h expected %b %0d %h %h",
                                 it, op, {op_done, div_zero}, n, hi, lo, eng_force_dz ? 2'b01 : 2'b10,
                                 eng_lat + 1, model_hi, model_lo);
            end
          end
        end
        default: begin
          checks++;
          if ({busy, rd_valid, op_done, div_zero, eng_start} !== 5'b0 || {hi, lo} !== {model_hi, model_lo}) begin
            errors++; $display("FAIL rand_nop it=%0d: flags=%b hi=%h lo=%h expected 00000 %h %h",
                               it, {busy, rd_valid, op_done, div_zero, eng_start}, hi, lo, model_hi, model_lo);
          end
        end
      endcase
      eng_force_dz = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_move_read();
    test_mult_latency();
    test_back_to_back();
    test_div_zero();
    test_timeout();
    test_spurious_done();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Initiator side of the iterative multiply/divide engine: accepts HI/LO-class instructions from the control unit, launches the engine with a start/done handshake and owns the architectural Hi/Lo registers.
- Stalls the control unit while an operation is in flight and serves MFHI/MFLO/MTHI/MTLO locally.
- Flags divide-by-zero and engine timeout to the exception logic.

Parameters:
- WIDTH, 32, operand and Hi/Lo width.
- TIMEOUT, 40, maximum WAIT cycles before the engine is declared hung.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  control unit presents an operation.
- req_op  input  3  0 NOP, 1 MULT, 2 DIV, 3 MFHI, 4 MFLO, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- req_a  input  WIDTH  rs operand.
- req_b  input  WIDTH  rt operand.
- req_ready  output  1  sequencer can accept a request.
- busy  output  1  operation in flight; stall request to the control unit.
- rd_valid  output  1  one-cycle pulse; rd_data holds the MFHI/MFLO result.
- rd_data  output  WIDTH  read result.
- hi, lo  output  WIDTH  architectural Hi/Lo registers.
- op_done  output  1  one-cycle pulse when MULT/DIV commits.
- div_zero  output  1  one-cycle pulse on divide-by-zero.
- timeout  output  1  one-cycle pulse on engine timeout.
- eng_start  output  1  one-cycle launch pulse to the engine.
- eng_ctrl  output  2  01 mult, 10 div, 00 idle; held through WAIT.
- eng_a, eng_b  output  WIDTH  operands, held stable from ISSUE until done or abort.
- eng_done  input  1  engine result pulse.
- eng_hi, eng_lo  input  WIDTH  engine results, valid with eng_done.
- eng_divzero  input  1  engine divide-by-zero flag, sampled with eng_done.

Behaviour:
- Reset values: state IDLE; hi, lo, rd_data, eng_a, eng_b, eng_ctrl = 0; all pulse outputs and busy = 0.
- req_ready = (state == IDLE) && !reset. A request is accepted when req_valid && req_ready.
- busy = (state != IDLE).
- FSM states are IDLE, ISSUE and WAIT.
- IDLE, accepting MFHI/MFLO: rd_data <= hi/lo and rd_valid = 1 on the next cycle. Stay in IDLE.
- IDLE, accepting MTHI/MTLO: hi/lo <= req_a, visible on the next cycle. Stay in IDLE.
- IDLE, accepting NOP or reserved: no effect.
- IDLE, accepting MULT: latch eng_a/eng_b and eng_ctrl=01, then go to ISSUE.
- IDLE, accepting DIV with req_b != 0: latch eng_a/eng_b and eng_ctrl=10, then go to ISSUE.
- IDLE, accepting DIV with req_b == 0: do not start the engine. Pulse div_zero next cycle; hi/lo unchanged; stay in IDLE.
- ISSUE: eng_start = 1 for exactly this cycle. Clear the watchdog counter and go to WAIT.
- WAIT, eng_done=1 and eng_divzero=0: hi <= eng_hi, lo <= eng_lo. op_done pulses next cycle; eng_ctrl <= 00; go to IDLE.
- WAIT, eng_done=1 and eng_divzero=1: hi/lo unchanged. div_zero pulses next cycle; eng_ctrl <= 00; go to IDLE.
- WAIT, no eng_done: the counter increments. When the counter reaches TIMEOUT-1 without eng_done, pulse timeout next cycle, set eng_ctrl <= 00, go to IDLE, hi/lo unchanged.
- eng_done is ignored outside WAIT, including a spurious done during ISSUE.
- Latency: request accepted at cycle 0 → eng_start at cycle 1 → engine done at cycle N → hi/lo updated, op_done high and req_ready high at cycle N+1.
- Back-to-back: a new request may be accepted in the same cycle that op_done is high.
- Reset mid-operation: return to IDLE immediately and clear hi/lo. eng_ctrl=00 makes the engine ignore any later done.
- Watchdog counter width is clog2(TIMEOUT)+1. It never wraps; it saturates until the state exits.

Decomposition:
- Shared package multdiv_pkg holds:
  - op encodings (OP_NOP … OP_MTLO)
  - ENG_MULT/ENG_DIV/ENG_IDLE ctrl codes
  - state enum
- Natural sub-module: multdiv_watchdog (counter with clear, enable and expiry pulse).
- The remainder lives in multdiv_sequencer.

Test Plan:
- MTHI a=0x0000_1234, then MFHI → hi=0x1234 one cycle after acceptance; rd_valid pulse with rd_data=0x1234.
- MULT a=0xFFFF_FFFE, b=3, with bench engine model done after 33 cycles (hi=0xFFFF_FFFF, lo=0xFFFF_FFFA):
  - eng_start exactly 1 cycle after acceptance;
  - busy high and req_ready low for 34 cycles;
  - op_done, hi and lo committed at done+1.
- MFLO presented while MULT in WAIT → req_ready=0 and request held; accepted at op_done cycle; rd_data = new lo.
- DIV a=7, b=0 → no eng_start; div_zero pulse next cycle; hi/lo unchanged. Engine returning eng_divzero=1 → div_zero pulse and no commit.
- Engine model never asserts done with TIMEOUT=40 → timeout pulse 41 cycles after eng_start; state IDLE; hi/lo unchanged.
- reset asserted 10 cycles into DIV → next cycle IDLE, hi=lo=0, eng_ctrl=00; a subsequent late eng_done is ignored.
